spi_slave_acc_model: RTL and testbench

- SPI responder (mode 0) that emulates the on-board 3-axis accelerometer register interface, so the SPI master and accelerometer control FSM can be exercised in simulation and on hardware loopback without the real sensor.
- Oversamples SCLK/CS_n/MOSI in the i_Clk domain and decodes the command byte (0x0A write, 0x0B read), the address byte and auto-incrementing data bytes.
- Serves ID, axis-sample and configuration registers; X/Y/Z samples come from ports.

---
 rtl/spi_slave_acc_model.sv | 275 +++++++++++++++++++++++++++
 tb/tb_spi_slave_acc_model.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_acc_model.sv
// -----------------------------------------------------------------------------
// spi_slave_acc_model
//
// SPI mode-0 responder that stands in for the on-board 3-axis accelerometer.
// SCLK/CS_n/MOSI are oversampled in the i_Clk domain. The first byte of a
// transaction is the command (0x0A write, 0x0B read), the second is the start
// address, and every following byte is a data byte at an auto-incrementing
// address.
//
// Ports:
//   i_Clk, i_Rst_L          system clock, async active-low reset
//   i_SPI_Clk/CS_n/MOSI     SPI bus from the master (asynchronous to i_Clk)
//   o_SPI_MISO              read data, driven only while serving a read
//   i_X/Y/Z_Data            12-bit signed axis samples
//   i_Sample_Valid          strobe qualifying the axis inputs
//   o_Wr_Valid/Addr/Data    one-cycle report of each accepted register write
//   o_Power_Ctl             live value of register 0x2D
//   o_Cmd_Err               pulse on an unsupported command byte
//   o_Xfer_Done             pulse when CS_n deasserts
//
// Build option: define SPI_SLV_STATUS_EN to add the STATUS register at 0x0B
// (bit0 DATA_READY). Without it 0x0B reads 0x00.
// -----------------------------------------------------------------------------
module spi_slave_acc_model #(
   parameter int         SYNC_STAGES = 2,
   parameter logic [7:0] DEVID_AD    = 8'hAD,
   parameter logic [7:0] DEVID_MST   = 8'h1D,
   parameter logic [7:0] PART_ID     = 8'hF2,
   parameter logic [7:0] REV_ID      = 8'h02
) (
   input  logic        i_Clk,
   input  logic        i_Rst_L,
   input  logic        i_SPI_Clk,
   input  logic        i_SPI_CS_n,
   input  logic        i_SPI_MOSI,
   output logic        o_SPI_MISO,
   input  logic [11:0] i_X_Data,
   input  logic [11:0] i_Y_Data,
   input  logic [11:0] i_Z_Data,
   input  logic        i_Sample_Valid,
   output logic        o_Wr_Valid,
   output logic [7:0]  o_Wr_Addr,
   output logic [7:0]  o_Wr_Data,
   output logic [7:0]  o_Power_Ctl,
   output logic        o_Cmd_Err,
   output logic        o_Xfer_Done
);

   typedef enum logic [2:0] {
      S_IDLE, S_CMD, S_ADDR, S_WR_DATA, S_RD_DATA, S_IGNORE
   } state_t;

   localparam logic [7:0] CMD_WR  = 8'h0A;
   localparam logic [7:0] CMD_RD  = 8'h0B;
   localparam logic [7:0] RST_KEY = 8'h52;

   // ---------------------------------------------------------------- sync
   logic [SYNC_STAGES-1:0] r_sclk_sync, r_cs_sync, r_mosi_sync;
   logic                   r_sclk_q, r_cs_q;
   logic                   w_sclk, w_cs_n, w_mosi;
   logic                   w_sclk_rise, w_sclk_fall, w_cs_fall, w_cs_rise;

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         r_sclk_sync <= '0;
         r_cs_sync   <= '1;   // bus idles deselected
         r_mosi_sync <= '0;
         r_sclk_q    <= 1'b0;
         r_cs_q      <= 1'b1;
      end else begin
         r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_SPI_Clk};
         r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0],   i_SPI_CS_n};
         r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_SPI_MOSI};
         r_sclk_q    <= w_sclk;
         r_cs_q      <= w_cs_n;
      end
   end

   assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
   assign w_cs_n      = r_cs_sync[SYNC_STAGES-1];
   assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
   assign w_sclk_rise =  w_sclk & ~r_sclk_q;
   assign w_sclk_fall = ~w_sclk &  r_sclk_q;
   assign w_cs_fall   = ~w_cs_n &  r_cs_q;
   assign w_cs_rise   =  w_cs_n & ~r_cs_q;

   // ------------------------------------------------------ bit/byte capture
   logic [2:0] r_bit_cnt;
   logic [6:0] r_rx_sr;
   logic [7:0] w_rx_byte;
   logic       w_byte_done;
   state_t     r_state, w_state_nxt;

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         r_bit_cnt <= 3'd0;
         r_rx_sr   <= 7'd0;
      end else if (w_cs_fall) begin
         r_bit_cnt <= 3'd0;
      end else if (w_sclk_rise) begin
         r_bit_cnt <= r_bit_cnt + 3'd1;
         r_rx_sr   <= {r_rx_sr[5:0], w_mosi};
      end
   end

   // The eighth bit is taken straight from the synchronizer so the whole byte
   // is usable in the cycle of its last rising edge.
   assign w_rx_byte   = {r_rx_sr, w_mosi};
   // A CS_n rise in the same cycle discards the byte.
   assign w_byte_done = w_sclk_rise & (r_bit_cnt == 3'd7) & ~w_cs_rise &
                        (r_state != S_IDLE);

   // -------------------------------------------------------------- FSM
   logic w_cmd_err, w_wr_en;
   logic r_is_rd;

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cmd_err   = 1'b0;
      w_wr_en     = 1'b0;
      if (w_cs_rise) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:    if (w_cs_fall) w_state_nxt = S_CMD;
            S_CMD:
               if (w_byte_done) begin
                  if (w_rx_byte == CMD_WR || w_rx_byte == CMD_RD) begin
                     w_state_nxt = S_ADDR;
                  end else begin
                     w_state_nxt = S_IGNORE;
                     w_cmd_err   = 1'b1;
                  end
               end
            S_ADDR:
               if (w_byte_done) w_state_nxt = r_is_rd ? S_RD_DATA : S_WR_DATA;
            S_WR_DATA: if (w_byte_done) w_wr_en = 1'b1;
            default: ;
         endcase
      end
   end

   // --------------------------------------------------- register storage
   logic [7:0]  r_cfg [16];           // 0x20..0x2F; entry 15 is never written
   logic [11:0] r_x, r_y, r_z;
   logic [7:0]  r_addr, r_tx_sr, w_rd_data;
   logic        r_load_pend, w_wr_ok, w_capture;

   assign w_wr_ok   = (r_addr == 8'h1F) || (r_addr >= 8'h20 && r_addr <= 8'h2E);
   // Shadows freeze while selected so a burst reads one coherent sample.
   assign w_capture = i_Sample_Valid & w_cs_n;

`ifdef SPI_SLV_STATUS_EN
   logic r_data_ready, r_axis_rd;

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         r_data_ready <= 1'b0;
         r_axis_rd    <= 1'b0;
      end else begin
         if (w_cs_rise || w_cs_fall)
            r_axis_rd <= 1'b0;
         else if (r_state == S_RD_DATA && w_sclk_fall && r_load_pend &&
                  r_addr >= 8'h0E && r_addr <= 8'h13)
            r_axis_rd <= 1'b1;
         // A new capture outranks the end-of-burst clear.
         if (w_capture)
            r_data_ready <= 1'b1;
         else if (w_cs_rise && r_axis_rd)
            r_data_ready <= 1'b0;
      end
   end
`endif

   always_comb begin
      w_rd_data = 8'h00;
      case (r_addr)
         8'h00: w_rd_data = DEVID_AD;
         8'h01: w_rd_data = DEVID_MST;
         8'h02: w_rd_data = PART_ID;
         8'h03: w_rd_data = REV_ID;
         8'h08: w_rd_data = r_x[11:4];
         8'h09: w_rd_data = r_y[11:4];
         8'h0A: w_rd_data = r_z[11:4];
`ifdef SPI_SLV_STATUS_EN
         8'h0B: w_rd_data = {7'd0, r_data_ready};
`endif
         8'h0E: w_rd_data = r_x[7:0];
         8'h0F: w_rd_data = {{4{r_x[11]}}, r_x[11:8]};
         8'h10: w_rd_data = r_y[7:0];
         8'h11: w_rd_data = {{4{r_y[11]}}, r_y[11:8]};
         8'h12: w_rd_data = r_z[7:0];
         8'h13: w_rd_data = {{4{r_z[11]}}, r_z[11:8]};
         default:
            if (r_addr >= 8'h20 && r_addr <= 8'h2E) w_rd_data = r_cfg[r_addr[3:0]];
      endcase
   end

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         r_is_rd     <= 1'b0;
         r_addr      <= 8'h00;
         r_tx_sr     <= 8'h00;
         r_load_pend <= 1'b0;
         r_x         <= 12'd0;
         r_y         <= 12'd0;
         r_z         <= 12'd0;
         o_Wr_Valid  <= 1'b0;
         o_Wr_Addr   <= 8'h00;
         o_Wr_Data   <= 8'h00;
         o_Cmd_Err   <= 1'b0;
         o_Xfer_Done <= 1'b0;
         for (int i = 0; i < 16; i++) r_cfg[i] <= (i == 12) ? 8'h13 : 8'h00;
      end else begin
         o_Wr_Valid  <= 1'b0;
         o_Cmd_Err   <= w_cmd_err;
         o_Xfer_Done <= w_cs_rise;

         if (w_capture) begin
            r_x <= i_X_Data;
            r_y <= i_Y_Data;
            r_z <= i_Z_Data;
         end

         if (w_cs_fall) r_tx_sr <= 8'h00;
         if (w_cs_rise || w_cs_fall) r_load_pend <= 1'b0;

         if (r_state == S_CMD && w_byte_done) r_is_rd <= (w_rx_byte == CMD_RD);

         if (r_state == S_ADDR && w_byte_done) begin
            r_addr      <= w_rx_byte;
            r_load_pend <= r_is_rd;     // first read byte loads on next fall
         end

         if (w_wr_en) begin
            r_addr <= r_addr + 8'd1;
            if (w_wr_ok) begin
               o_Wr_Valid <= 1'b1;
               o_Wr_Addr  <= r_addr;
               o_Wr_Data  <= w_rx_byte;
               if (r_addr == 8'h1F) begin
                  if (w_rx_byte == RST_KEY)
                     for (int i = 0; i < 16; i++) r_cfg[i] <= (i == 12) ? 8'h13 : 8'h00;
               end else begin
                  r_cfg[r_addr[3:0]] <= w_rx_byte;
               end
            end
         end

         // Reads: the fall after each completed byte loads the next register,
         // every other fall shifts the next bit onto MISO.
         if (r_state == S_RD_DATA) begin
            if (w_byte_done) r_load_pend <= 1'b1;
            if (w_sclk_fall) begin
               if (r_load_pend) begin
                  r_tx_sr     <= w_rd_data;
                  r_addr      <= r_addr + 8'd1;
                  r_load_pend <= 1'b0;
               end else begin
                  r_tx_sr <= {r_tx_sr[6:0], 1'b0};
               end
            end
         end
      end
   end

   assign o_Power_Ctl = r_cfg[13];
   assign o_SPI_MISO  = (r_state == S_RD_DATA) & r_tx_sr[7];

endmodule

// File: tb/tb_spi_slave_acc_model.sv
module tb_spi_slave_acc_model;
   localparam int HALF = 8;   // SCLK half period in i_Clk cycles

   logic        clk = 1'b0, rst_n = 1'b0;
   logic        sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0, sv = 1'b0;
   logic [11:0] xd = '0, yd = '0, zd = '0;
   logic        miso, wr_valid, cmd_err, xfer_done;
   logic [7:0]  wr_addr, wr_data, pwr;

   always #5 clk = ~clk;

   spi_slave_acc_model dut (
      .i_Clk(clk), .i_Rst_L(rst_n),
      .i_SPI_Clk(sclk), .i_SPI_CS_n(cs_n), .i_SPI_MOSI(mosi), .o_SPI_MISO(miso),
      .i_X_Data(xd), .i_Y_Data(yd), .i_Z_Data(zd), .i_Sample_Valid(sv),
      .o_Wr_Valid(wr_valid), .o_Wr_Addr(wr_addr), .o_Wr_Data(wr_data),
      .o_Power_Ctl(pwr), .o_Cmd_Err(cmd_err), .o_Xfer_Done(xfer_done));

   int errors = 0, checks = 0;
   int n_wr = 0, n_err = 0, n_done = 0;
   logic [7:0] last_wa = 8'h00, last_wd = 8'h00;

   always @(posedge clk) begin
      if (wr_valid) begin
         n_wr    <= n_wr + 1;
         last_wa <= wr_addr;
         last_wd <= wr_data;
      end
      if (cmd_err)   n_err  <= n_err + 1;
      if (xfer_done) n_done <= n_done + 1;
   end

   // ---------------------------------------------------- reference model
   logic [7:0]  m_cfg [16];
   logic [11:0] m_x = '0, m_y = '0, m_z = '0;
   bit          m_dr = 1'b0;
   int          exp_wr = 0;
   logic [7:0]  exp_wa = 8'h00, exp_wd = 8'h00;

   function automatic void m_reset_cfg();
      for (int i = 0; i < 16; i++) m_cfg[i] = 8'h00;
      m_cfg[12] = 8'h13;
   endfunction

   function automatic bit m_writable(input logic [7:0] a);
      return a == 8'h1F || (a >= 8'h20 && a <= 8'h2E);
   endfunction

   // Axis pair = 16-bit sign-extended sample, low byte first.
   function automatic logic [7:0] m_axis(input logic [11:0] v, input bit hi);
      logic signed [15:0] s;
      s = 16'($signed(v));
      return hi ? s[15:8] : s[7:0];
   endfunction

   function automatic logic [7:0] m_read(input logic [7:0] a);
      case (a)
         8'h00: return 8'hAD;
         8'h01: return 8'h1D;
         8'h02: return 8'hF2;
         8'h03: return 8'h02;
         8'h08: return 8'(m_x >> 4);
         8'h09: return 8'(m_y >> 4);
         8'h0A: return 8'(m_z >> 4);
`ifdef SPI_SLV_STATUS_EN
         8'h0B: return m_dr ? 8'h01 : 8'h00;
`endif
         8'h0E, 8'h0F: return m_axis(m_x, a[0]);
         8'h10, 8'h11: return m_axis(m_y, a[0]);
         8'h12, 8'h13: return m_axis(m_z, a[0]);
         default: if (a >= 8'h20 && a <= 8'h2E) return m_cfg[int'(a) - 32];
      endcase
      return 8'h00;
   endfunction

   function automatic void m_write(input logic [7:0] a, input logic [7:0] d);
      if (!m_writable(a)) return;
      exp_wr++;
      exp_wa = a;
      exp_wd = d;
      if (a == 8'h1F) begin
         if (d == 8'h52) m_reset_cfg();
      end else begin
         m_cfg[int'(a) - 32] = d;
      end
   endfunction

   // ---------------------------------------------------- bus drivers
   logic [7:0]  tx_buf [16];
   logic [7:0]  rx_buf [16];
   logic [11:0] s_x, s_y, s_z;   // values strobed mid-burst

   task automatic xfer(input int nb, input int last_bits, input int strobe_at);
      int nbit;
      cs_n = 1'b0;
      for (int b = 0; b < nb; b++) begin
         nbit = (b == nb - 1) ? last_bits : 8;
         if (b == strobe_at) begin
            xd = s_x; yd = s_y; zd = s_z; sv = 1'b1;
            @(negedge clk);
            sv = 1'b0;
         end
         rx_buf[b] = 8'h00;
         for (int i = 7; i > 7 - nbit; i--) begin
            mosi = tx_buf[b][i];
            repeat (HALF) @(negedge clk);
            rx_buf[b][i] = miso;   // master samples on the rising edge
            sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
         end
      end
      repeat (HALF) @(negedge clk);
      cs_n = 1'b1;
      mosi = 1'b0;
      repeat (10) @(negedge clk);
   endtask

   // Read n data bytes from a; a fall after every completed byte loads one
   // register, so a..a+n are all loaded.
   task automatic rd_burst(input logic [7:0] a, input int n, input int strobe_at);
      bit hit;
      logic [7:0] ad;
      tx_buf[0] = 8'h0B;
      tx_buf[1] = a;
      for (int k = 0; k < n; k++) tx_buf[2 + k] = 8'($urandom);
      xfer(n + 2, 8, strobe_at);
      hit = 1'b0;
      for (int k = 0; k <= n; k++) begin
         ad = a + 8'(k);
         if (ad >= 8'h0E && ad <= 8'h13) hit = 1'b1;
      end
      if (hit) m_dr = 1'b0;
   endtask

   task automatic wr_burst(input logic [7:0] a, input logic [7:0] d0,
                           input logic [7:0] d1, input int nd);
      tx_buf[0] = 8'h0A; tx_buf[1] = a; tx_buf[2] = d0; tx_buf[3] = d1;
      xfer(2 + nd, 8, -1);
      m_write(a, d0);
      if (nd > 1) m_write(a + 8'd1, d1);
   endtask

   task automatic do_sample(input logic [11:0] x, input logic [11:0] y,
                            input logic [11:0] z);
      @(negedge clk);
      xd = x; yd = y; zd = z; sv = 1'b1;
      @(negedge clk);
      sv = 1'b0;
      repeat (2) @(negedge clk);
      m_x = x; m_y = y; m_z = z; m_dr = 1'b1;
   endtask

   // ---------------------------------------------------- tests
   task automatic test_reset();
      m_reset_cfg();
      rst_n = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (miso !== 1'b0) begin errors++; $display("FAIL reset_miso got %b want 0", miso); end
      checks++; if ({wr_valid, cmd_err, xfer_done} !== 3'b000) begin errors++; $display("FAIL reset_pulses got %b want 000", {wr_valid, cmd_err, xfer_done}); end
      checks++; if ({wr_addr, wr_data} !== 16'h0000) begin errors++; $display("FAIL reset_wr got %h want 0000", {wr_addr, wr_data}); end
      checks++; if (pwr !== 8'h00) begin errors++; $display("FAIL reset_pwr got %h want 00", pwr); end
   endtask

   task automatic test_id_read();
      int d0;
      d0 = n_done;
      rd_burst(8'h00, 4, -1);
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (rx_buf[2 + k] !== m_read(8'(k))) begin
            errors++; $display("FAIL id_byte%0d got %h want %h", k, rx_buf[2 + k], m_read(8'(k)));
         end
      end
      checks++; if (n_done !== d0 + 1) begin errors++; $display("FAIL id_xfer_done got %0d want %0d", n_done - d0, 1); end
   endtask

   task automatic test_axis();
      logic [7:0] exp6 [6];
      logic [7:0] fix6 [6];
      fix6 = '{8'h85, 8'hFF, 8'h7F, 8'h00, 8'h00, 8'hF8};
      do_sample(12'hF85, 12'h07F, 12'h800);
      for (int k = 0; k < 6; k++) exp6[k] = m_read(8'h0E + 8'(k));
      rd_burst(8'h0E, 6, -1);
      for (int k = 0; k < 6; k++) begin
         checks++;
         if (rx_buf[2 + k] !== exp6[k] || exp6[k] !== fix6[k]) begin
            errors++; $display("FAIL axis_lo%0d got %h want %h", k, rx_buf[2 + k], fix6[k]);
         end
      end
      rd_burst(8'h08, 3, -1);
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (rx_buf[2 + k] !== m_read(8'h08 + 8'(k))) begin
            errors++; $display("FAIL axis_hi%0d got %h want %h", k, rx_buf[2 + k], m_read(8'h08 + 8'(k)));
         end
      end
   endtask

   task automatic test_write();
      int w0;
      w0 = n_wr;
      wr_burst(8'h2D, 8'h02, 8'h00, 1);
      checks++; if (n_wr !== w0 + 1) begin errors++; $display("FAIL wr_count got %0d want 1", n_wr - w0); end
      checks++; if ({last_wa, last_wd} !== 16'h2D02) begin errors++; $display("FAIL wr_addr_data got %h want 2d02", {last_wa, last_wd}); end
      checks++; if (pwr !== 8'h02) begin errors++; $display("FAIL wr_pwr got %h want 02", pwr); end
      wr_burst(8'h1F, 8'h52, 8'h00, 1);
      checks++; if (n_wr !== w0 + 2) begin errors++; $display("FAIL rst_key_count got %0d want 2", n_wr - w0); end
      checks++; if (pwr !== 8'h00) begin errors++; $display("FAIL rst_key_pwr got %h want 00", pwr); end
      rd_burst(8'h2C, 1, -1);
      checks++; if (rx_buf[2] !== 8'h13) begin errors++; $display("FAIL rst_key_2c got %h want 13", rx_buf[2]); end
   endtask

   task automatic test_cmd_err();
      int e0, w0;
      logic [7:0] ored;
      e0 = n_err; w0 = n_wr;
      tx_buf[0] = 8'h0D; tx_buf[1] = 8'h00; tx_buf[2] = 8'h55; tx_buf[3] = 8'hAA;
      xfer(4, 8, -1);
      ored = rx_buf[0] | rx_buf[1] | rx_buf[2] | rx_buf[3];
      checks++; if (n_err !== e0 + 1) begin errors++; $display("FAIL cmd_err_count got %0d want 1", n_err - e0); end
      checks++; if (ored !== 8'h00) begin errors++; $display("FAIL cmd_err_miso got %h want 00", ored); end
      checks++; if (n_wr !== w0) begin errors++; $display("FAIL cmd_err_writes got %0d want 0", n_wr - w0); end
   endtask

   task automatic test_partial();
      int w0;
      wr_burst(8'h20, 8'h3C, 8'h00, 1);
      w0 = n_wr;
      tx_buf[0] = 8'h0A; tx_buf[1] = 8'h20; tx_buf[2] = 8'hFF;
      xfer(3, 5, -1);
      checks++; if (n_wr !== w0) begin errors++; $display("FAIL partial_writes got %0d want 0", n_wr - w0); end
      rd_burst(8'h20, 1, -1);
      checks++; if (rx_buf[2] !== m_read(8'h20)) begin errors++; $display("FAIL partial_reg20 got %h want %h", rx_buf[2], m_read(8'h20)); end
   endtask

   task automatic test_sample_in_burst();
      logic [7:0] exp6 [6];
      do_sample(12'h123, 12'hABC, 12'h7FF);
      for (int k = 0; k < 6; k++) exp6[k] = m_read(8'h0E + 8'(k));
      s_x = 12'h456; s_y = 12'h001; s_z = 12'hFFF;
      rd_burst(8'h0E, 6, 4);   // strobe lands mid-burst and must be dropped
      for (int k = 0; k < 6; k++) begin
         checks++;
         if (rx_buf[2 + k] !== exp6[k]) begin
            errors++; $display("FAIL burst_coherent%0d got %h want %h", k, rx_buf[2 + k], exp6[k]);
         end
      end
      do_sample(s_x, s_y, s_z);
      for (int k = 0; k < 6; k++) exp6[k] = m_read(8'h0E + 8'(k));
      rd_burst(8'h0E, 6, -1);
      for (int k = 0; k < 6; k++) begin
         checks++;
         if (rx_buf[2 + k] !== exp6[k]) begin
            errors++; $display("FAIL burst_new%0d got %h want %h", k, rx_buf[2 + k], exp6[k]);
         end
      end
   endtask

   task automatic test_status();
      logic [7:0] want;
      do_sample(12'h321, 12'h654, 12'h987);
`ifdef SPI_SLV_STATUS_EN
      want = 8'h01;
`else
      want = 8'h00;
`endif
      rd_burst(8'h0B, 1, -1);
      checks++; if (rx_buf[2] !== want || m_read(8'h0B) !== want) begin errors++; $display("FAIL status_set got %h want %h", rx_buf[2], want); end
      rd_burst(8'h0E, 6, -1);
      rd_burst(8'h0B, 1, -1);
      checks++; if (rx_buf[2] !== 8'h00) begin errors++; $display("FAIL status_clr got %h want 00", rx_buf[2]); end
   endtask

   task automatic test_random();
      logic [7:0] a, d0, d1, ra;
      logic [7:0] exp4 [4];
      for (int it = 0; it < 10; it++) begin
         a  = 8'($urandom_range(8'h1E, 8'h2F));
         d0 = 8'($urandom);
         d1 = 8'($urandom);
         if ($urandom_range(0, 3) == 0) begin a = 8'h1F; d0 = 8'h52; end
         wr_burst(a, d0, d1, 2);
         checks++; if (n_wr !== exp_wr) begin errors++; $display("FAIL rnd_wr_count it%0d got %0d want %0d", it, n_wr, exp_wr); end
         checks++; if ({last_wa, last_wd} !== {exp_wa, exp_wd}) begin errors++; $display("FAIL rnd_wr_last it%0d got %h want %h", it, {last_wa, last_wd}, {exp_wa, exp_wd}); end
         checks++; if (pwr !== m_cfg[13]) begin errors++; $display("FAIL rnd_pwr it%0d got %h want %h", it, pwr, m_cfg[13]); end
         if ($urandom_range(0, 1) == 1)
            do_sample(12'($urandom), 12'($urandom), 12'($urandom));
         ra = (it % 3 == 0) ? 8'($urandom_range(8'h08, 8'h12)) : 8'($urandom_range(8'h1C, 8'h2C));
         for (int k = 0; k < 4; k++) exp4[k] = m_read(ra + 8'(k));
         rd_burst(ra, 4, -1);
         for (int k = 0; k < 4; k++) begin
            checks++;
            if (rx_buf[2 + k] !== exp4[k]) begin
               errors++; $display("FAIL rnd_rd it%0d addr %h got %h want %h", it, ra + 8'(k), rx_buf[2 + k], exp4[k]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_id_read();
      test_axis();
      test_write();
      test_cmd_err();
      test_partial();
      test_sample_in_burst();
      test_status();
      exp_wr = n_wr;   // align the running write count before random traffic
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
